// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Initiator side of an 8-bit ALU operand/result interface. A command is
// accepted over a valid/ready channel. Its operands and opcode are registered
// onto the combinational ALU and held for SETTLE_CYCLES cycles, and then the
// 16-bit ALU result is captured. The result and its status flags are returned
// over a valid/ready response channel. An 8-bit accumulator lets commands
// chain results without a round-trip through the host.
//
// Handshake rule (both channels): a transfer happens at a rising clk edge
// where valid and ready are both 1. The producer holds valid and payload
// stable until that edge. Ready never depends combinationally on valid.
//
// Parameters:
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    sequencer can accept a command (registered)
//   cmd_op       ADD=000 SUB=001 MUL=010 DIV=011 AND=100 OR=101 NEG=110 XOR=111
//   cmd_a        operand A, used when cmd_use_acc=0
//   cmd_b        operand B
//   cmd_use_acc  1: operand A is taken from the accumulator
//   cmd_wb       1: write res[7:0] to the accumulator at capture
//   alu_a        ALU operand A (registered)
//   alu_b        ALU operand B (registered)
//   alu_sel      ALU opcode (registered)
//   alu_res      ALU result, combinational from alu_a/alu_b/alu_sel
//   rsp_valid    response present (registered)
//   rsp_ready    consumer accepts response
//   rsp_data     captured result
//   rsp_zero     rsp_data == 0
//   rsp_dbz      op was DIV with operand B == 0
//   acc          current accumulator value
//   op_count     completed responses, wraps 0xFFFF -> 0

module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_use_acc,
    input  logic        cmd_wb,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [15:0] alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_dbz,
    output logic [7:0]  acc,
    output logic [15:0] op_count
);

    localparam logic [2:0] OP_DIV      = 3'b011;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The state register is kept as a named enum so that checkers can bind
    // to it hierarchically (u_dut.state).
    state_t     state;
    logic [3:0] settle_cnt;
    logic       wb_q;

    // cmd_ready and rsp_valid are flops that are updated together with the
    // state. This means no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_dbz    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            acc        <= '0;
            op_count   <= '0;
            settle_cnt <= '0;
            wb_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // The accumulator is sampled at the accept edge. Any
                        // write-back from the previous op landed well before.
                        alu_a      <= cmd_use_acc ? acc : cmd_a;
                        alu_b      <= cmd_b;
                        alu_sel    <= cmd_op;
                        wb_q       <= cmd_wb;
                        settle_cnt <= SETTLE_LOAD;
                        cmd_ready  <= 1'b0;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_data  <= alu_res;
                        rsp_zero  <= (alu_res == 16'd0);
                        // Divide-by-zero is decided from the operands driven
                        // to the ALU, not from the value the ALU returns.
                        rsp_dbz   <= (alu_sel == OP_DIV) && (alu_b == 8'd0);
                        if (wb_q) begin
                            acc <= alu_res[7:0];
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        // cmd_ready rises only in the following cycle. There
                        // is no same-cycle bypass from the response to the
                        // next command.
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Two instances are built, with SETTLE_CYCLES
// of 1 and 4. Each instance is driven by its own behavioural ALU, and both
// are exercised from one sequential stimulus process.
module tb_alu_op_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [2];
  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic [2:0]  cmd_op      [2];
  logic [7:0]  cmd_a       [2];
  logic [7:0]  cmd_b       [2];
  logic        cmd_use_acc [2];
  logic        cmd_wb      [2];
  logic [7:0]  alu_a       [2];
  logic [7:0]  alu_b       [2];
  logic [2:0]  alu_sel     [2];
  logic [15:0] alu_res     [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [15:0] rsp_data    [2];
  logic        rsp_zero    [2];
  logic        rsp_dbz     [2];
  logic [7:0]  acc         [2];
  logic [15:0] op_count    [2];

  // Behavioural ALU. The 16-bit result uses two's complement for SUB and NEG.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] a16, b16;
    a16 = {8'd0, a};
    b16 = {8'd0, b};
    case (op)
      3'd0: return a16 + b16;
      3'd1: return a16 - b16;
      3'd2: return a16 * b16;
      3'd3: return (b == 8'd0) ? 16'd0 : a16 / b16;
      3'd4: return a16 & b16;
      3'd5: return a16 | b16;
      3'd6: return 16'd0 - a16;
      default: return a16 ^ b16;
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_op_sequencer #(.SETTLE_CYCLES(k == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst[k]),
      .cmd_valid(cmd_valid[k]), .cmd_ready(cmd_ready[k]), .cmd_op(cmd_op[k]),
      .cmd_a(cmd_a[k]), .cmd_b(cmd_b[k]), .cmd_use_acc(cmd_use_acc[k]), .cmd_wb(cmd_wb[k]),
      .alu_a(alu_a[k]), .alu_b(alu_b[k]), .alu_sel(alu_sel[k]), .alu_res(alu_res[k]),
      .rsp_valid(rsp_valid[k]), .rsp_ready(rsp_ready[k]), .rsp_data(rsp_data[k]),
      .rsp_zero(rsp_zero[k]), .rsp_dbz(rsp_dbz[k]), .acc(acc[k]), .op_count(op_count[k])
    );
    assign alu_res[k] = alu_fn(alu_sel[k], alu_a[k], alu_b[k]);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  acc_m [2];
  logic [15:0] cnt_m [2];
  logic [7:0]  m_a, m_b;
  logic [2:0]  m_op;
  logic        m_wb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic reset_dut(input int k);
    rst[k] = 1'b1;
    cmd_valid[k] = 1'b0;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b0;
    acc_m[k] = 8'd0;
    cnt_m[k] = 16'd0;
    exp_q.delete();
    check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check("rst_rsp_data",  32'(rsp_data[k]),  32'd0);
    check("rst_flags",     32'({rsp_zero[k], rsp_dbz[k]}), 32'd0);
    check("rst_alu",       32'({alu_a[k], alu_b[k], alu_sel[k]}), 32'd0);
    check("rst_acc",       32'(acc[k]),      32'd0);
    check("rst_op_count",  32'(op_count[k]), 32'd0);
  endtask

  // Presents one command and returns at the negedge after the accept edge.
  task automatic issue_cmd(input int k, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic use_acc, input logic wb);
    m_a  = use_acc ? acc_m[k] : a;
    m_b  = b;
    m_op = op;
    m_wb = wb;
    exp_q.push_back(alu_fn(op, m_a, b));
    check("cmd_ready_idle", 32'(cmd_ready[k]), 32'd1);
    cmd_valid[k] = 1'b1;
    cmd_op[k] = op;
    cmd_a[k] = a;
    cmd_b[k] = b;
    cmd_use_acc[k] = use_acc;
    cmd_wb[k] = wb;
    @(negedge clk);
    cmd_valid[k] = 1'b0;
  endtask

  // Settle phase, response checks, backpressure for 'hold' cycles, handshake.
  task automatic finish_op(input int k, input int hold);
    logic [15:0] exp;
    for (int i = 0; i < settle_of(k); i++) begin
      check("issue_alu", 32'({alu_a[k], alu_b[k], alu_sel[k]}), 32'({m_a, m_b, m_op}));
      check("issue_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("issue_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    if (m_wb) acc_m[k] = exp[7:0];
    check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
    check("rsp_data",  32'(rsp_data[k]),  32'(exp));
    check("rsp_zero",  32'(rsp_zero[k]),  32'(exp == 16'd0));
    check("rsp_dbz",   32'(rsp_dbz[k]),   32'(m_op == 3'd3 && m_b == 8'd0));
    check("acc",       32'(acc[k]),       32'(acc_m[k]));
    for (int j = 0; j < hold; j++) begin
      if (j == 0) begin
        cmd_valid[k] = 1'b1;
        cmd_a[k] = ~m_a;
        cmd_b[k] = ~m_b;
        cmd_use_acc[k] = 1'b0;
      end
      @(negedge clk);
      cmd_valid[k] = 1'b0;
      check("bp_rsp_valid", 32'(rsp_valid[k]), 32'd1);
      check("bp_rsp_data",  32'(rsp_data[k]),  32'(exp));
      check("bp_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      check("bp_alu_hold",  32'({alu_a[k], alu_b[k]}), 32'({m_a, m_b}));
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    cnt_m[k] = cnt_m[k] + 16'd1;
    check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("op_count",       32'(op_count[k]),  32'(cnt_m[k]));
    check("idle_alu_hold",  32'({alu_a[k], alu_b[k], alu_sel[k]}), 32'({m_a, m_b, m_op}));
  endtask

  task automatic do_op(input int k, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc, input logic wb,
                       input int hold);
    issue_cmd(k, op, a, b, use_acc, wb);
    finish_op(k, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      cmd_valid[k] = 1'b0;
      cmd_op[k] = '0;
      cmd_a[k] = '0;
      cmd_b[k] = '0;
      cmd_use_acc[k] = 1'b0;
      cmd_wb[k] = 1'b0;
      rsp_ready[k] = 1'b0;
    end
    reset_dut(1);
    for (int k = 0; k < 2; k++) begin
      reset_dut(k);
      // Directed operations.
      do_op(k, 3'd0, 8'd200, 8'd100, 1'b0, 1'b0, 0);
      do_op(k, 3'd2, 8'd255, 8'd255, 1'b0, 1'b0, 0);
      do_op(k, 3'd3, 8'd7,   8'd0,   1'b0, 1'b0, 0);
      do_op(k, 3'd3, 8'd200, 8'd7,   1'b0, 1'b0, 0);
      // Accumulator chain.
      reset_dut(k);
      for (int n = 0; n < 3; n++) do_op(k, 3'd0, 8'd0, 8'd3, 1'b1, 1'b1, 0);
      do_op(k, 3'd1, 8'd0, 8'd10, 1'b1, 1'b0, 0);
      // Backpressure.
      do_op(k, 3'd7, 8'hAA, 8'h0F, 1'b0, 1'b0, 5);
      // Reset during ISSUE.
      issue_cmd(k, 3'd0, 8'd50, 8'd60, 1'b0, 1'b1);
      reset_dut(k);
      do_op(k, 3'd0, 8'd1, 8'd1, 1'b0, 1'b0, 0);
      // Reset during RESP with rsp_ready low.
      issue_cmd(k, 3'd2, 8'd9, 8'd9, 1'b0, 1'b1);
      repeat (settle_of(k)) @(negedge clk);
      reset_dut(k);
      do_op(k, 3'd0, 8'd1, 8'd1, 1'b0, 1'b0, 0);
      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
        logic [2:0] op;
        logic [7:0] a, b;
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom_range(0, 255));
        b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        do_op(k, op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
